// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file: NRD combinational read ports, two writeback
// lanes, optional write-to-read bypass and a per-register busy scoreboard.
module regfile_mp_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   raddr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]      rbusy,
   input  logic                we0,
   input  logic [AW-1:0]       waddr0,
   input  logic [XLEN-1:0]     wdata0,
   input  logic                we1,
   input  logic [AW-1:0]       waddr1,
   input  logic [XLEN-1:0]     wdata1,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_rd,
   output logic [NREGS-1:0]    busy_vec
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // Lane 1 is applied after lane 0 so it wins an address collision.
   always_comb begin
      regs_d = regs_q;
      if (we0 && !(ZERO_REG && waddr0 == '0)) regs_d[waddr0] = wdata0;
      if (we1 && !(ZERO_REG && waddr1 == '0)) regs_d[waddr1] = wdata1;
   end

   always_comb begin
      busy_d = busy_q;
      for (int r = 0; r < NREGS; r++) begin
         if (iss_valid && iss_rd == AW'(r) && !(ZERO_REG && r == 0))
            busy_d[r] = 1'b1;
         else if ((we0 && waddr0 == AW'(r)) || (we1 && waddr1 == AW'(r)))
            busy_d[r] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd;

      assign ra = raddr[i*AW +: AW];

      // Busy comes from registered state only; the issue stage folds in write matches.
      always_comb begin
         rd = regs_q[ra];
         if (BYPASS && !rst) begin
            if (we1 && waddr1 == ra)      rd = wdata1;
            else if (we0 && waddr0 == ra) rd = wdata0;
         end
         if (ZERO_REG && ra == '0) rd = '0;
      end

      assign rdata[i*XLEN +: XLEN] = rd;
      assign rbusy[i]              = busy_q[ra];
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: bypass, no-bypass and no-zero-register instances
// share one stimulus stream; expected values are hand-computed constants.
module tb_regfile_mp_sb;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int NRD   = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic [NRD*AW-1:0]   raddr;
   logic                we0, we1, iss_valid;
   logic [AW-1:0]       waddr0, waddr1, iss_rd;
   logic [XLEN-1:0]     wdata0, wdata1;
   logic [NRD*XLEN-1:0] rdata_b, rdata_n, rdata_z;
   logic [NRD-1:0]      rbusy_b, rbusy_n, rbusy_z;
   logic [NREGS-1:0]    busy_b, busy_n, busy_z;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_b (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_b));

   regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_n (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_n));

   regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut_z (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_z), .rbusy(rbusy_z),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_z));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      we0 = 1'b0; waddr0 = '0; wdata0 = '0;
      we1 = 1'b0; waddr1 = '0; wdata1 = '0;
      iss_valid = 1'b0; iss_rd = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rsel(input int p, input logic [AW-1:0] a);
      raddr[p*AW +: AW] = a;
      #1;
   endtask

   function automatic logic [XLEN-1:0] port(input logic [NRD*XLEN-1:0] v, input int p);
      return v[p*XLEN +: XLEN];
   endfunction

   initial begin
      rst = 1'b1;
      raddr = '0;
      idle();
      step();
      step();
      rst = 1'b0;
      #1;
      check("init_busy", busy_b, 32'h0);
      check("init_rd0", port(rdata_b, 0), 32'h0);
      check("init_rbusy", {28'h0, rbusy_b}, 32'h0);

      // Fill regs 1..31 and mark each one busy as it is written.
      for (int r = 1; r < NREGS; r++) begin
         we0 = 1'b1; waddr0 = AW'(r); wdata0 = 32'hA5A5_0000 + r;
         iss_valid = 1'b1; iss_rd = AW'(r);
         step();
      end
      idle();
      rsel(0, 5'd17);
      check("load_r17", port(rdata_b, 0), 32'hA5A5_0011);
      check("load_busy", busy_b, 32'hFFFF_FFFE);

      // Reset with a write and issue pending; bypass must not apply under rst.
      rst = 1'b1;
      we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hFFFF_FFFF;
      iss_valid = 1'b1; iss_rd = 5'd6;
      rsel(0, 5'd5);
      check("rst_nobyp", port(rdata_b, 0), 32'hA5A5_0005);
      step();
      rst = 1'b0;
      idle();
      for (int r = 0; r < NREGS; r++) begin
         rsel(0, AW'(r));
         check($sformatf("rst_rd%0d", r), port(rdata_b, 0), 32'h0);
      end
      check("rst_busy_b", busy_b, 32'h0);
      check("rst_busy_n", busy_n, 32'h0);
      check("rst_busy_z", busy_z, 32'h0);
      check("rst_rbusy", {28'h0, rbusy_b}, 32'h0);

      // Write/read and register 0.
      we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h1234_5678;
      we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hDEAD_BEEF;
      rsel(0, 5'd3);
      rsel(1, 5'd0);
      check("byp_r3", port(rdata_b, 0), 32'h1234_5678);
      check("nobyp_r3", port(rdata_n, 0), 32'h0);
      check("byp_x0", port(rdata_b, 1), 32'h0);
      check("noz_byp_r0", port(rdata_z, 1), 32'hDEAD_BEEF);
      step();
      idle();
      #1;
      check("wr_r3_b", port(rdata_b, 0), 32'h1234_5678);
      check("wr_r3_n", port(rdata_n, 0), 32'h1234_5678);
      check("wr_x0", port(rdata_b, 1), 32'h0);
      check("noz_r0", port(rdata_z, 1), 32'hDEAD_BEEF);

      // Dual-write collision on reg 7.
      we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h77;
      step();
      we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
      we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
      rsel(0, 5'd7);
      check("coll_byp", port(rdata_b, 0), 32'h22);
      check("coll_nobyp", port(rdata_n, 0), 32'h77);
      step();
      idle();
      #1;
      check("coll_r7_b", port(rdata_b, 0), 32'h22);
      check("coll_r7_n", port(rdata_n, 0), 32'h22);
      we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'h88;
      rsel(2, 5'd8);
      check("lane0_byp", port(rdata_b, 2), 32'h88);
      check("lane0_nobyp", port(rdata_n, 2), 32'h0);
      step();
      idle();

      // Scoreboard lifecycle on reg 9, then an issue to reg 0.
      iss_valid = 1'b1; iss_rd = 5'd9;
      rsel(3, 5'd9);
      check("sb_set_same", busy_b, 32'h0);
      step();
      idle();
      #1;
      check("sb_set", busy_b, 32'h0000_0200);
      check("sb_rbusy", {28'h0, rbusy_b}, 32'h8);
      we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99;
      #1;
      check("sb_wb_rbusy", {28'h0, rbusy_b}, 32'h8);
      check("sb_wb_byp", port(rdata_b, 3), 32'h99);
      check("sb_wb_nobyp", port(rdata_n, 3), 32'h0);
      step();
      idle();
      #1;
      check("sb_clr", busy_b, 32'h0);
      iss_valid = 1'b1; iss_rd = 5'd0;
      step();
      idle();
      #1;
      check("sb_x0", busy_b, 32'h0);
      check("noz_sb_r0", busy_z, 32'h1);

      // Set and clear of reg 12 in the same cycle.
      iss_valid = 1'b1; iss_rd = 5'd12;
      step();
      iss_valid = 1'b1; iss_rd = 5'd12;
      we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h55;
      step();
      idle();
      rsel(0, 5'd12);
      check("setclr_busy", busy_b, 32'h0000_1000);
      check("setclr_data", port(rdata_b, 0), 32'h55);
      we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h56;
      step();
      idle();
      #1;
      check("setclr_clr", busy_b, 32'h0);

      // All four read ports, reg 2 busy.
      we0 = 1'b1; waddr0 = 5'd1;  wdata0 = 32'h0101;
      we1 = 1'b1; waddr1 = 5'd31; wdata1 = 32'h3131;
      step();
      we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'h0202;
      iss_valid = 1'b1; iss_rd = 5'd2;
      step();
      idle();
      rsel(0, 5'd1);
      rsel(1, 5'd2);
      rsel(2, 5'd1);
      rsel(3, 5'd31);
      check("mp_p0", port(rdata_b, 0), 32'h0101);
      check("mp_p1", port(rdata_b, 1), 32'h0202);
      check("mp_p2", port(rdata_b, 2), 32'h0101);
      check("mp_p3", port(rdata_b, 3), 32'h3131);
      check("mp_p3_n", port(rdata_n, 3), 32'h3131);
      check("mp_rbusy", {28'h0, rbusy_b}, 32'h2);
      check("mp_rbusy_n", {28'h0, rbusy_n}, 32'h2);
      check("mp_busy", busy_b, 32'h0000_0004);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file for the next-generation core. It replaces the single-write, two-read file with:
- NRD read ports and two write ports;
- optional same-cycle write-to-read bypass;
- a per-register busy scoreboard that the issue stage uses to detect RAW hazards on in-flight writebacks.

The block sits between decode/issue (read, busy-set) and the writeback stage (two retire lanes).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers; power of two, >= 2
AW, $clog2(NREGS), register address width (derived, not overridden)
NRD, 2, number of read ports, 1..4
BYPASS, 1, 1 = read ports return same-cycle write data; 0 = return stored value
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
raddr  in  NRD*AW  packed read addresses; port i at [i*AW +: AW]
rdata  out  NRD*XLEN  packed read data; port i at [i*XLEN +: XLEN]
rbusy  out  NRD  busy flag of the register addressed by each read port
we0  in  1  write enable, lane 0
waddr0  in  AW  write address, lane 0
wdata0  in  XLEN  write data, lane 0
we1  in  1  write enable, lane 1
waddr1  in  AW  write address, lane 1
wdata1  in  XLEN  write data, lane 1
iss_valid  in  1  issue of an instruction that will write iss_rd
iss_rd  in  AW  destination register being issued
busy_vec  out  NREGS  full scoreboard, bit r = register r pending

Behaviour:
Reset:
- rst high at a clock edge: all NREGS registers <= 0, all busy bits <= 0.
- we0, we1 and iss_valid in that cycle are ignored.
- After reset, rdata reads 0 for every address; rbusy = 0 and busy_vec = 0.

Reads:
- Combinational, zero latency from raddr.
- BYPASS=0: rdata[i] = stored[raddr[i]].
- BYPASS=1, priority: lane 1 match (we1 && waddr1==raddr[i]), else lane 0 match, else stored value.
- Bypass never applies while rst=1.

Writes:
- Take effect at the clock edge; visible in storage on the next cycle.
- Both lanes to the same address in one cycle: lane 1 wins, lane 0 data is dropped.

ZERO_REG=1:
- Writes to address 0 are discarded.
- rdata for address 0 is always 0, including under bypass.
- busy bit 0 is never set.
- ZERO_REG=0: register 0 behaves like any other register.

Scoreboard, per register r, next-state at each edge:
- set = iss_valid && iss_rd==r.
- clr = (we0 && waddr0==r) || (we1 && waddr1==r).
- Set and clear in the same cycle: set wins (new producer issued as the old one retires).
- Otherwise set -> 1, clr -> 0, else hold.
- Write to a non-busy register: legal, clears nothing extra.

rbusy:
- rbusy[i] = busy[raddr[i]], taken from registered state, not bypassed.
- A same-cycle writeback therefore still shows busy that cycle. BYPASS data is valid regardless; the issue stage combines it with the write-match itself.

Out-of-range addresses cannot occur (NREGS = 2^AW).

No X on any output after the first reset.

Test Plan:
- Reset clears state: load regs 1..31 with 32'hA5A5_0000+r, assert rst one cycle with we0=1 waddr0=5 wdata0=32'hFFFF_FFFF -> all reads 0, busy_vec=0, reg 5 = 0.
- Write/read and x0: we0 waddr0=3 wdata0=32'h1234_5678, we1 waddr1=0 wdata1=32'hDEAD_BEEF -> next cycle raddr=3 gives 32'h1234_5678, raddr=0 gives 0 (ZERO_REG=1).
- Dual-write collision: we0/we1 both to reg 7, data 32'h11 / 32'h22 -> reg 7 = 32'h22. Same cycle with BYPASS=1 and raddr=7 -> rdata=32'h22. With BYPASS=0 -> old value.
- Scoreboard lifecycle: iss_valid iss_rd=9 -> busy_vec[9]=1 next cycle. Then we1 waddr1=9 -> busy_vec[9]=0 following cycle. Then iss_rd=0 -> busy_vec[0] stays 0.
- Set/clear same cycle: reg 12 busy; iss_valid iss_rd=12 together with we0 waddr0=12 wdata0=32'h55 -> reg 12 = 32'h55 and busy_vec[12] stays 1.
- All read ports (NRD=4): ports 0..3 read regs 1,2,1,31 while reg 2 is busy -> correct data on every port, rbusy=4'b0010.
